bf_weight_ctrl: RTL

Configuration controller for the 8-element beamformer datapath (BF_TOP).
- Accepts weight writes over a valid/ready port into a shadow bank.
- Generates the per-sample strobe (one per OSR fast clocks).
- Swaps shadow→active only on a sample boundary, so the w_cos_1/w_sin_1/w_cos_2/w_sin_2 buses feeding the modulators never change mid-sample.

---
 rtl/bf_weight_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/bf_weight_ctrl.sv
// bf_weight_ctrl
// ----------------------------------------------------------------------------
// Weight configuration controller for the 8-element beamformer datapath.
// Weights are written into a shadow bank over a valid/ready port. A commit
// request copies the whole shadow bank into the active bank, but only on a
// sample boundary. As a result, the weight buses feeding the modulators never
// change in the middle of a sample period.
//
// Ports
//   clock          system clock
//   reset          asynchronous active-low reset
//   cfg_valid      write request
//   cfg_ready      controller accepts a write this cycle (IDLE only)
//   cfg_addr       [4:3] set (0=cos_1, 1=sin_1, 2=cos_2, 3=sin_2), [2:0] element
//   cfg_data       weight value (two's complement, W_WIDTH bits)
//   cfg_commit     request a shadow->active swap at the next sample boundary
//   commit_pending swap requested and not yet completed
//   sample_stb     one-cycle pulse on the last clock of each sample period
//   w_cos_1/w_sin_1/w_cos_2/w_sin_2
//                  active weight sets; element k sits at [k*W_WIDTH +: W_WIDTH]
//   swap_count     number of completed swaps, modulo 256
//   cfg_err        (BF_WEIGHT_CLAMP_EN only) sticky flag, set by a clamped write
//
// Build option
//   BF_WEIGHT_CLAMP_EN : when defined, a write of the most-negative code is
//                        stored as most-negative + 1, and the cfg_err port is
//                        added.
// ----------------------------------------------------------------------------
module bf_weight_ctrl #(
  parameter int N_ELEM  = 8,
  parameter int W_WIDTH = 5,
  parameter int OSR     = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [4:0]                  cfg_addr,
  input  logic [W_WIDTH-1:0]          cfg_data,
  input  logic                        cfg_commit,
  output logic                        commit_pending,
  output logic                        sample_stb,
  output logic [N_ELEM*W_WIDTH-1:0]   w_cos_1,
  output logic [N_ELEM*W_WIDTH-1:0]   w_sin_1,
  output logic [N_ELEM*W_WIDTH-1:0]   w_cos_2,
  output logic [N_ELEM*W_WIDTH-1:0]   w_sin_2,
  output logic [7:0]                  swap_count
`ifdef BF_WEIGHT_CLAMP_EN
  ,
  output logic                        cfg_err
`endif
);

  localparam int BUS_W = N_ELEM * W_WIDTH;
  localparam int CNT_W = (OSR > 1) ? $clog2(OSR) : 1;

  // The counter value during which sample_stb is high, and the value one
  // cycle earlier. The registered strobe is loaded from the earlier value.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(OSR - 2);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_SWAP = 2'd2;

`ifdef BF_WEIGHT_CLAMP_EN
  localparam logic [W_WIDTH-1:0] MOST_NEG = {1'b1, {(W_WIDTH-1){1'b0}}};

  // Map the most-negative code to most-negative + 1 so the range is symmetric.
  function automatic logic [W_WIDTH-1:0] clamp_weight(input logic [W_WIDTH-1:0] d);
    logic [W_WIDTH-1:0] res;
    if (d == MOST_NEG) begin
      res = MOST_NEG | {{(W_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      res = d;
    end
    return res;
  endfunction
`endif

  logic [1:0]       state_r;
  logic [1:0]       state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             stb_r;
  logic             cfg_ready_r;
  logic             commit_pending_r;
  logic [7:0]       swap_count_r;
  logic             wr_en_s;
  logic             swap_en_s;
  logic [1:0]       wr_set_s;
  logic [2:0]       wr_elem_s;
  logic [W_WIDTH-1:0] wr_data_s;
  logic [BUS_W-1:0] shadow_r [0:3];
  logic [BUS_W-1:0] act_cos_1_r;
  logic [BUS_W-1:0] act_sin_1_r;
  logic [BUS_W-1:0] act_cos_2_r;
  logic [BUS_W-1:0] act_sin_2_r;

  assign wr_en_s   = cfg_valid && cfg_ready_r;
  assign wr_set_s  = cfg_addr[4:3];
  assign wr_elem_s = cfg_addr[2:0];
  // The strobe seen in PEND always belongs to a later period than the commit,
  // because the strobe drops at the same edge that registers the commit.
  assign swap_en_s = (state_r == ST_PEND) && stb_r;

`ifdef BF_WEIGHT_CLAMP_EN
  assign wr_data_s = clamp_weight(cfg_data);
`else
  assign wr_data_s = cfg_data;
`endif

  // Free-running sample-phase counter and registered end-of-sample strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
      stb_r <= 1'b0;
    end else begin
      if (cnt_r == CNT_LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      stb_r <= (cnt_r == CNT_PRE);
    end
  end

  // Next-state logic for the commit FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cfg_commit) begin
          state_next_s = ST_PEND;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (stb_r) begin
          state_next_s = ST_SWAP;
        end else begin
          state_next_s = ST_PEND;
        end
      end
      ST_SWAP: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM state plus handshake/status outputs, registered from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r          <= ST_IDLE;
      cfg_ready_r      <= 1'b0;
      commit_pending_r <= 1'b0;
    end else begin
      state_r          <= state_next_s;
      cfg_ready_r      <= (state_next_s == ST_IDLE);
      commit_pending_r <= (state_next_s != ST_IDLE);
    end
  end

  // Shadow bank: accepted writes land here; the active bank is untouched.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < 4; s++) begin
        shadow_r[s] <= '0;
      end
    end else if (wr_en_s) begin
      shadow_r[wr_set_s][int'(wr_elem_s)*W_WIDTH +: W_WIDTH] <= wr_data_s;
    end
  end

  // Active bank. Loading it at the strobe edge places the new weights on the
  // first clock of the next sample period. The bank drives the outputs directly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      act_cos_1_r  <= '0;
      act_sin_1_r  <= '0;
      act_cos_2_r  <= '0;
      act_sin_2_r  <= '0;
      swap_count_r <= 8'd0;
    end else if (swap_en_s) begin
      act_cos_1_r  <= shadow_r[0];
      act_sin_1_r  <= shadow_r[1];
      act_cos_2_r  <= shadow_r[2];
      act_sin_2_r  <= shadow_r[3];
      swap_count_r <= swap_count_r + 8'd1;
    end
  end

`ifdef BF_WEIGHT_CLAMP_EN
  // Sticky error flag, set whenever an accepted write had to be clamped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cfg_err <= 1'b0;
    end else if (wr_en_s && (cfg_data == MOST_NEG)) begin
      cfg_err <= 1'b1;
    end
  end
`endif

  assign cfg_ready      = cfg_ready_r;
  assign commit_pending = commit_pending_r;
  assign sample_stb     = stb_r;
  assign swap_count     = swap_count_r;
  assign w_cos_1        = act_cos_1_r;
  assign w_sin_1        = act_sin_1_r;
  assign w_cos_2        = act_cos_2_r;
  assign w_sin_2        = act_sin_2_r;

endmodule
